// File: rtl/cnt_mod_chain.sv
// Cascaded modulo-MODULUS up/down counter chain with parallel load and sticky wrap flag.
// Latency: q updates one ck edge after load/count; ca is combinational from the current count.
// Backpressure: none; every enabled edge counts, and load always takes priority over counting.
module cnt_mod_chain #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int DIGITS  = 4
) (
    input  logic                      ck,
    input  logic                      res,
    input  logic                      en,
    input  logic                      up,
    input  logic                      ld,
    input  logic [DIGITS*WIDTH-1:0]   d,
    output logic [DIGITS*WIDTH-1:0]   q,
    output logic                      ca,
    output logic                      ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULUS);

    logic [DIGITS*WIDTH-1:0] q_q, q_d;
    logic                    ovf_q, ovf_d;

    // lo_max[i] / lo_zero[i]: every digit below i sits at its top / bottom value
    logic [DIGITS:0]         lo_max, lo_zero;
    logic [WIDTH-1:0]        dig, fld;

    // Next-count: load with per-digit clamp, else ripple the step through the digits
    always_comb begin
        q_d        = q_q;
        lo_max     = '0;
        lo_zero    = '0;
        dig        = '0;
        fld        = '0;
        lo_max[0]  = 1'b1;
        lo_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_q[i*WIDTH +: WIDTH];
            fld = d[i*WIDTH +: WIDTH];
            lo_max[i+1]  = lo_max[i]  & (dig == MAXV);
            lo_zero[i+1] = lo_zero[i] & (dig == '0);
            if (ld) begin
                // Out-of-range load fields saturate so no digit can ever exceed MODULUS-1
                q_d[i*WIDTH +: WIDTH] = ({1'b0, fld} >= MODV) ? MAXV : fld;
            end else if (en) begin
                if (up && lo_max[i]) begin
                    q_d[i*WIDTH +: WIDTH] = (dig == MAXV) ? '0 : dig + WIDTH'(1);
                end else if (!up && lo_zero[i]) begin
                    q_d[i*WIDTH +: WIDTH] = (dig == '0) ? MAXV : dig - WIDTH'(1);
                end
            end
        end
    end

    // Whole-chain wrap indication; load suppresses it so ld always wins
    assign ca = en & ~ld & (up ? lo_max[DIGITS] : lo_zero[DIGITS]);

    // Sticky wrap flag: set by a chain wrap, cleared only by load (or reset)
    assign ovf_d = ld ? 1'b0 : (ovf_q | ca);

    // Count and flag registers; reset forces zero immediately, independent of ck
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_cnt_mod_chain.sv
// Self-checking bench for cnt_mod_chain with two BCD digits (WIDTH=4, MODULUS=10).
// Reference model keeps the count as a plain integer 0..99 plus a sticky wrap bit.
// Inputs change one time unit after each rising edge; outputs are sampled away from the edge.
module tb_cnt_mod_chain;

    logic       ck;
    logic       res;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] d;
    logic [7:0] q;
    logic       ca;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_v;
    bit m_ovf;

    cnt_mod_chain #(.WIDTH(4), .MODULUS(10), .DIGITS(2)) dut (
        .ck  (ck),
        .res (res),
        .en  (en),
        .up  (up),
        .ld  (ld),
        .d   (d),
        .q   (q),
        .ca  (ca),
        .ovf (ovf)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int digit_clamp(input logic [3:0] x);
        return (int'(x) >= 10) ? 9 : int'(x);
    endfunction

    function automatic int load_val(input logic [7:0] dv);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = dv[7:4];
        lo = dv[3:0];
        return digit_clamp(hi) * 10 + digit_clamp(lo);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit model_ca(input bit e, input bit u, input bit l);
        return e && !l && (u ? (m_v == 99) : (m_v == 0));
    endfunction

    task automatic model_step(input bit e, input bit u, input bit l, input logic [7:0] dv);
        if (l) begin
            m_v   = load_val(dv);
            m_ovf = 1'b0;
        end else if (e) begin
            if (u) begin
                if (m_v == 99) begin
                    m_v   = 0;
                    m_ovf = 1'b1;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                if (m_v == 0) begin
                    m_v   = 99;
                    m_ovf = 1'b1;
                end else begin
                    m_v = m_v - 1;
                end
            end
        end
    endtask

    // One clock cycle against the model; entered and left at posedge+1
    task automatic cycle(input string nm, input bit e, input bit u, input bit l, input logic [7:0] dv);
        en = e;
        up = u;
        ld = l;
        d  = dv;
        #1;
        chk({nm, ".ca"}, 32'(ca), 32'(model_ca(e, u, l)));
        @(posedge ck);
        model_step(e, u, l, dv);
        #1;
        chk({nm, ".q"}, 32'(q), 32'(to_bcd(m_v)));
        chk({nm, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    typedef struct {
        bit         e;
        bit         u;
        bit         l;
        logic [7:0] dv;
        logic [7:0] exp_q;
        bit         exp_ca;
        bit         exp_ovf;
    } vec_t;

    vec_t tab[16];

    initial begin
        // Directed sequence; each entry follows from the previous one's state
        tab[0]  = '{0, 0, 1, 8'h98, 8'h98, 0, 0};
        tab[1]  = '{1, 1, 0, 8'h00, 8'h99, 0, 0};
        tab[2]  = '{1, 1, 0, 8'h00, 8'h00, 1, 1};
        tab[3]  = '{1, 0, 1, 8'h01, 8'h01, 0, 0};
        tab[4]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0};
        tab[5]  = '{1, 0, 0, 8'h00, 8'h99, 1, 1};
        tab[6]  = '{1, 0, 0, 8'h00, 8'h98, 0, 1};
        tab[7]  = '{1, 1, 0, 8'h00, 8'h99, 0, 1};
        tab[8]  = '{1, 1, 1, 8'hF3, 8'h93, 0, 0};
        tab[9]  = '{0, 0, 1, 8'h40, 8'h40, 0, 0};
        tab[10] = '{0, 0, 0, 8'h00, 8'h40, 0, 0};
        tab[11] = '{0, 1, 0, 8'h00, 8'h40, 0, 0};
        tab[12] = '{0, 0, 0, 8'h00, 8'h40, 0, 0};
        tab[13] = '{1, 0, 0, 8'h00, 8'h39, 0, 0};
        tab[14] = '{1, 1, 0, 8'h00, 8'h40, 0, 0};
        tab[15] = '{0, 1, 1, 8'h5C, 8'h59, 0, 0};

        res   = 1'b1;
        en    = 1'b0;
        up    = 1'b0;
        ld    = 1'b0;
        d     = 8'h00;
        m_v   = 0;
        m_ovf = 1'b0;

        // Reset state: asserted between edges, visible before any clock
        #2 res = 1'b0;
        #1;
        chk("reset.q", 32'(q), 32'h00);
        chk("reset.ovf", 32'(ovf), 32'h0);
        chk("reset.ca", 32'(ca), 32'h0);
        @(posedge ck);
        #1 res = 1'b1;

        // Up-count from reset for 12 edges
        for (int i = 0; i < 12; i++) cycle("upcount", 1, 1, 0, 8'h00);
        chk("upcount.final_q", 32'(q), 32'h12);
        chk("upcount.final_ovf", 32'(ovf), 32'h0);

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            en = tab[i].e;
            up = tab[i].u;
            ld = tab[i].l;
            d  = tab[i].dv;
            #1;
            chk($sformatf("tab%0d.ca", i), 32'(ca), 32'(tab[i].exp_ca));
            @(posedge ck);
            model_step(tab[i].e, tab[i].u, tab[i].l, tab[i].dv);
            #1;
            chk($sformatf("tab%0d.q", i), 32'(q), 32'(tab[i].exp_q));
            chk($sformatf("tab%0d.ovf", i), 32'(ovf), 32'(tab[i].exp_ovf));
        end

        // Async reset mid-count with ovf set and q=0x57
        cycle("pre_rst.ld", 0, 0, 1, 8'h00);
        cycle("pre_rst.wrap", 1, 0, 0, 8'h00);
        for (int i = 0; i < 42; i++) cycle("pre_rst.dn", 1, 0, 0, 8'h00);
        chk("pre_rst.q", 32'(q), 32'h57);
        chk("pre_rst.ovf", 32'(ovf), 32'h1);
        en = 1'b1;
        up = 1'b0;
        ld = 1'b0;
        #2 res = 1'b0;
        #1;
        chk("arst.q_immediate", 32'(q), 32'h00);
        chk("arst.ovf_immediate", 32'(ovf), 32'h0);
        chk("arst.ca_down", 32'(ca), 32'h1);
        up = 1'b1;
        #1;
        chk("arst.ca_up", 32'(ca), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge ck);
            #1;
            chk("arst.hold_q", 32'(q), 32'h00);
            chk("arst.hold_ovf", 32'(ovf), 32'h0);
        end
        m_v   = 0;
        m_ovf = 1'b0;
        res   = 1'b1;

        // First edge after release counts normally
        cycle("release", 1, 1, 0, 8'h00);
        chk("release.q", 32'(q), 32'h01);

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            bit e;
            bit u;
            bit l;
            logic [7:0] dv;
            e  = ($urandom_range(0, 99) < 85);
            u  = ($urandom_range(0, 99) < 50);
            l  = ($urandom_range(0, 99) < 5);
            dv = 8'($urandom);
            cycle("rand", e, u, l, dv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
